// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU with a one-deep response register.
// Optional per-requester grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

  logic             prio_reg, prio_next;
  logic             rsp_valid_reg, rsp_valid_next;
  logic             rsp_id_reg, rsp_id_next;
  logic [WIDTH-1:0] rsp_result_reg, rsp_result_next;
  logic             rsp_zero_reg, rsp_zero_next;
  logic             rsp_err_reg, rsp_err_next;

  logic             can_accept;
  logic             any_valid;
  logic             grant;
  logic             accept;
  logic [2:0]       gnt_op;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;
  logic             gnt_legal;
  logic [1:0][15:0] cnt_vec;

  // The response slot frees up in the same cycle the consumer drains it.
  assign can_accept = !reset && (!rsp_valid_reg || rsp_ready);
  assign any_valid  = req0_valid || req1_valid;
  assign accept     = can_accept && any_valid;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio_reg;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign gnt_op    = grant ? req1_op : req0_op;
  assign gnt_a     = grant ? req1_a  : req0_a;
  assign gnt_b     = grant ? req1_b  : req0_b;
  assign gnt_legal = op_legal(gnt_op);

  // Operands go to the ALU only on an accept so idle requesters cannot toggle it.
  always_comb begin
    alu_control = 3'b000;
    alu_src_a   = '0;
    alu_src_b   = '0;
    if (accept) begin
      alu_control = gnt_legal ? gnt_op : 3'b000;
      alu_src_a   = gnt_a;
      alu_src_b   = gnt_b;
    end
  end

  always_comb begin
    prio_next       = prio_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_result_next = rsp_result_reg;
    rsp_zero_next   = rsp_zero_reg;
    rsp_err_next    = rsp_err_reg;
    if (accept) begin
      prio_next      = !grant;
      rsp_valid_next = 1'b1;
      rsp_id_next    = grant;
      if (gnt_legal) begin
        rsp_result_next = alu_result;
        rsp_zero_next   = alu_zero;
        rsp_err_next    = 1'b0;
      end else begin
        rsp_result_next = '0;
        rsp_zero_next   = 1'b1;
        rsp_err_next    = 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg       <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      prio_reg       <= prio_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_result_reg <= rsp_result_next;
      rsp_zero_reg   <= rsp_zero_next;
      rsp_err_reg    <= rsp_err_next;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign rsp_err    = rsp_err_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt_reg;
    // Saturating so a long-running requester never wraps back to a small count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (accept && (grant == 1'(gi)) && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign cnt_vec[gi] = cnt_reg;
`else
    assign cnt_vec[gi] = 16'h0000;
`endif
  end

  assign cnt0 = cnt_vec[0];
  assign cnt1 = cnt_vec[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, corner-case sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   alu_control;
  logic [W-1:0] alu_src_a, alu_src_b;
  logic [W-1:0] alu_result;
  logic         alu_zero;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [W-1:0] rsp_result;
  logic [15:0]  cnt0, cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Architectural result of an opcode; illegal codes give result 0.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return '0;
    endcase
  endfunction

  // Shared ALU the arbiter drives.
  always_comb begin
    alu_result = alu_fn(alu_control, alu_src_a, alu_src_b);
    alu_zero   = (alu_result == '0);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic v0, input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic v1, input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic rr);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready = rr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic v0; logic [2:0] op0; logic [W-1:0] a0; logic [W-1:0] b0;
    logic v1; logic [2:0] op1; logic [W-1:0] a1; logic [W-1:0] b1;
    logic rr;
    logic e_r0; logic e_r1; logic [2:0] e_ctrl;
    logic e_valid; logic e_id; logic [W-1:0] e_res; logic e_zero; logic e_err;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic v1, input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                              input logic rr, input logic e_r0, input logic e_r1, input logic [2:0] e_ctrl,
                              input logic e_valid, input logic e_id, input logic [W-1:0] e_res,
                              input logic e_zero, input logic e_err);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ctrl = e_ctrl;
    v.e_valid = e_valid; v.e_id = e_id; v.e_res = e_res; v.e_zero = e_zero; v.e_err = e_err;
    return v;
  endfunction

  // Reference model state: pending response, round-robin pointer, grant totals.
  logic         m_prio, m_valid, m_id, m_zero, m_err;
  logic [W-1:0] m_res;
  int           m_cnt0, m_cnt1;

  task automatic model_reset();
    m_prio = 0; m_valid = 0; m_id = 0; m_res = '0; m_zero = 0; m_err = 0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  vec_t vecs[11];

  initial begin
    logic exp_acc, exp_win, exp_legal;
    logic [2:0] w_op;
    logic [W-1:0] w_a, w_b;
    logic [15:0] e_c0, e_c1;

    // prio starts at 0 after reset; each accept hands priority to the loser.
    vecs[0]  = mk(1, 3'b001, 9, 9, 1, 3'b101, 3, 4, 1,  1, 0, 3'b001,  1, 0, 0, 1, 0);
    vecs[1]  = mk(1, 3'b001, 9, 9, 1, 3'b101, 3, 4, 1,  0, 1, 3'b101,  1, 1, 1, 0, 0);
    vecs[2]  = mk(1, 3'b001, 9, 9, 1, 3'b101, 3, 4, 1,  1, 0, 3'b001,  1, 0, 0, 1, 0);
    vecs[3]  = mk(1, 3'b001, 9, 9, 1, 3'b101, 3, 4, 1,  0, 1, 3'b101,  1, 1, 1, 0, 0);
    vecs[4]  = mk(1, 3'b000, 5, 7, 0, 3'b000, 0, 0, 1,  1, 0, 3'b000,  1, 0, 12, 0, 0);
    vecs[5]  = mk(1, 3'b110, 1, 1, 0, 3'b000, 0, 0, 1,  1, 0, 3'b000,  1, 0, 0, 1, 1);
    vecs[6]  = mk(0, 3'b011, 7, 7, 0, 3'b010, 3, 3, 1,  0, 0, 3'b000,  0, 0, 0, 1, 1);
    vecs[7]  = mk(0, 3'b000, 0, 0, 1, 3'b010, 32'hFF, 32'h0F, 0,  0, 1, 3'b010,  1, 1, 32'h0F, 0, 0);
    vecs[8]  = mk(1, 3'b000, 1, 1, 0, 3'b000, 0, 0, 0,  0, 0, 3'b000,  1, 1, 32'h0F, 0, 0);
    vecs[9]  = mk(1, 3'b000, 1, 1, 0, 3'b000, 0, 0, 1,  1, 0, 3'b000,  1, 0, 2, 0, 0);
    vecs[10] = mk(1, 3'b001, 0, 0, 0, 3'b000, 0, 0, 1,  1, 0, 3'b001,  1, 0, 0, 1, 0);

    reset = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    chk("reset_rsp_valid", W'(rsp_valid), 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_cnt0", W'(cnt0), 0);
    chk("reset_cnt1", W'(cnt1), 0);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      set_req(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
              vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
      #2;
      chk($sformatf("vec%0d_ready0", i), W'(req0_ready), W'(vecs[i].e_r0));
      chk($sformatf("vec%0d_ready1", i), W'(req1_ready), W'(vecs[i].e_r1));
      chk($sformatf("vec%0d_alu_control", i), W'(alu_control), W'(vecs[i].e_ctrl));
      @(negedge clk);
      chk($sformatf("vec%0d_rsp_valid", i), W'(rsp_valid), W'(vecs[i].e_valid));
      chk($sformatf("vec%0d_rsp_id", i), W'(rsp_id), W'(vecs[i].e_id));
      chk($sformatf("vec%0d_rsp_result", i), rsp_result, vecs[i].e_res);
      chk($sformatf("vec%0d_rsp_zero", i), W'(rsp_zero), W'(vecs[i].e_zero));
      chk($sformatf("vec%0d_rsp_err", i), W'(rsp_err), W'(vecs[i].e_err));
      $display("vec %0d: r0=%0b r1=%0b ctrl=%0d rsp v=%0b id=%0b res=0x%0h z=%0b e=%0b",
               i, vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_ctrl, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err);
    end

    // Backpressure: response held stable while consumer stalls
    do_reset();
    set_req(0, 0, 0, 0, 1, 3'b011, 32'hF0, 32'h0F, 0);
    #2 chk("bp_accept_ready1", W'(req1_ready), 1);
    @(negedge clk);
    chk("bp_rsp_result", rsp_result, 32'hFF);
    chk("bp_rsp_id", W'(rsp_id), 1);
    for (int k = 0; k < 3; k++) begin
      set_req(1, 3'b000, 2, 3, 1, 3'b010, 6, 5, 0);
      #2;
      chk($sformatf("bp_stall%0d_ready0", k), W'(req0_ready), 0);
      chk($sformatf("bp_stall%0d_ready1", k), W'(req1_ready), 0);
      chk($sformatf("bp_stall%0d_alu_a", k), alu_src_a, 0);
      @(negedge clk);
      chk($sformatf("bp_stall%0d_valid", k), W'(rsp_valid), 1);
      chk($sformatf("bp_stall%0d_result", k), rsp_result, 32'hFF);
      $display("stall %0d: rsp_valid=%0b rsp_result=0x%0h", k, rsp_valid, rsp_result);
    end
    set_req(1, 3'b000, 2, 3, 0, 0, 0, 0, 1);
    #2 chk("bp_release_ready0", W'(req0_ready), 1);
    chk("bp_release_alu_a", alu_src_a, 2);
    @(negedge clk);
    chk("bp_release_result", rsp_result, 5);
    chk("bp_release_id", W'(rsp_id), 0);
    chk("bp_release_valid", W'(rsp_valid), 1);

    // Reset while a response is held
    reset = 1'b1;
    set_req(1, 3'b000, 4, 4, 1, 3'b000, 8, 8, 0);
    #2;
    chk("rst_ready0", W'(req0_ready), 0);
    chk("rst_ready1", W'(req1_ready), 0);
    chk("rst_alu_src_a", alu_src_a, 0);
    @(negedge clk);
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_cnt0", W'(cnt0), 0);
    chk("rst_cnt1", W'(cnt1), 0);
    reset = 1'b0;
    #2;
    chk("post_rst_ready0", W'(req0_ready), 1);
    chk("post_rst_ready1", W'(req1_ready), 0);
    @(negedge clk);
    chk("post_rst_result", rsp_result, 8);
    $display("reset sequence: rsp_valid=%0b rsp_result=0x%0h", rsp_valid, rsp_result);

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] a0, a1;
      a0 = $urandom; a1 = $urandom;
      reset = ($urandom_range(0, 60) == 0);
      set_req($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), a0,
              ($urandom_range(0, 3) == 0) ? a0 : W'($urandom),
              $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), a1,
              ($urandom_range(0, 3) == 0) ? a1 : W'($urandom),
              $urandom_range(0, 3) != 0);
      exp_win = (req0_valid && req1_valid) ? m_prio : req1_valid;
      exp_acc = !reset && (!m_valid || rsp_ready) && (req0_valid || req1_valid);
      w_op = exp_win ? req1_op : req0_op;
      w_a  = exp_win ? req1_a : req0_a;
      w_b  = exp_win ? req1_b : req0_b;
      exp_legal = (w_op != 3'b100) && (w_op != 3'b110) && (w_op != 3'b111);
      #2;
      chk("rnd_ready0", W'(req0_ready), W'(exp_acc && !exp_win));
      chk("rnd_ready1", W'(req1_ready), W'(exp_acc && exp_win));
      chk("rnd_alu_control", W'(alu_control), (exp_acc && exp_legal) ? W'(w_op) : 0);
      chk("rnd_alu_src_a", alu_src_a, exp_acc ? w_a : 0);
      chk("rnd_alu_src_b", alu_src_b, exp_acc ? w_b : 0);
      if (reset) begin
        model_reset();
      end else if (exp_acc) begin
        m_valid = 1; m_id = exp_win; m_prio = !exp_win;
        m_res = alu_fn(w_op, w_a, w_b);
        m_zero = (m_res == '0); m_err = !exp_legal;
        if (exp_win) m_cnt1++; else m_cnt0++;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      @(negedge clk);
      chk("rnd_rsp_valid", W'(rsp_valid), W'(m_valid));
      chk("rnd_rsp_id", W'(rsp_id), W'(m_id));
      chk("rnd_rsp_result", rsp_result, m_res);
      chk("rnd_rsp_zero", W'(rsp_zero), W'(m_zero));
      chk("rnd_rsp_err", W'(rsp_err), W'(m_err));
      e_c0 = STATS ? ((m_cnt0 > 65535) ? 16'hFFFF : 16'(m_cnt0)) : 16'h0;
      e_c1 = STATS ? ((m_cnt1 > 65535) ? 16'hFFFF : 16'(m_cnt1)) : 16'h0;
      chk("rnd_cnt0", W'(cnt0), W'(e_c0));
      chk("rnd_cnt1", W'(cnt1), W'(e_c1));
      if (n % 500 == 0)
        $display("rnd %0d: acc=%0b win=%0b rsp v=%0b id=%0b res=0x%0h", n, exp_acc, exp_win, rsp_valid, rsp_id, rsp_result);
    end
    reset = 1'b0;

    // Counter saturation: 70000 back-to-back accepts from requester 1
    do_reset();
    set_req(0, 0, 0, 0, 1, 3'b000, 1, 2, 1);
    repeat (70000) @(negedge clk);
    chk("sat_cnt1", W'(cnt1), STATS ? W'(16'hFFFF) : 0);
    chk("sat_cnt0", W'(cnt0), 0);
    chk("sat_rsp_valid", W'(rsp_valid), 1);
    chk("sat_rsp_result", rsp_result, 3);
    $display("saturation run: cnt0=0x%0h cnt1=0x%0h", cnt0, cnt1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, datapath width of operands and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_op / req1_op  input  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-008 alu_control  output  3  opcode driven to the shared ALU.
REQ-009 alu_src_a, alu_src_b  output  WIDTH  operands driven to the shared ALU.
REQ-010 alu_result  input  WIDTH; alu_zero  input  1  combinational ALU outputs.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer takes the response this cycle.
REQ-013 rsp_id  output  1  requester that issued the held response.
REQ-014 rsp_result  output  WIDTH; rsp_zero  output  1; rsp_err  output  1  registered result, zero flag, illegal-op flag.
REQ-015 cnt0, cnt1  output  16  grant counters (see Configuration).

Function
REQ-016 can_accept = !rsp_valid || rsp_ready; no request SHALL be accepted when can_accept is 0.
REQ-017 Grant: one valid requester wins alone; both valid -> requester named by priority pointer prio wins.
REQ-018 reqN_ready SHALL be 1 only when can_accept and requester N is granted; combinational, never both 1.
REQ-019 On accept, prio SHALL become the non-granted requester; prio unchanged otherwise.
REQ-020 During an accept cycle alu_control/alu_src_a/alu_src_b SHALL carry the granted op/a/b; otherwise 3'b000, 0, 0.
REQ-021 Latency: on accept edge rsp_valid<=1, rsp_id<=grant, rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_err<=0; response visible the cycle after accept.
REQ-022 Illegal ops (100, 110, 111) SHALL be accepted, ALU outputs ignored, rsp_result<=0, rsp_zero<=1, rsp_err<=1; alu_control driven 3'b000.
REQ-023 rsp_valid && !rsp_ready: all rsp_* fields SHALL hold stable; no accept.
REQ-024 rsp_ready with no accept in the same cycle -> rsp_valid<=0 next edge; rsp_result/rsp_id hold previous values.
REQ-025 rsp_ready and accept in the same cycle -> back-to-back; rsp_valid stays 1 with new contents; sustained throughput one op/cycle.
REQ-026 rsp_ready while rsp_valid=0 SHALL have no effect.
REQ-027 Requester-side inputs with reqN_valid=0 SHALL not affect any output.

Reset
REQ-028 reset=1 at a rising edge: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, prio=0, cnt0=cnt1=0.
REQ-029 While reset=1, req0_ready=req1_ready=0 and ALU outputs idle values; a held response is discarded.
REQ-030 First cycle after reset release SHALL be able to accept.

Configuration
REQ-031 Macro ALU_ARB_STATS_EN defined: cntN increments by 1 on each accept for requester N, saturating at 16'hFFFF.
REQ-032 Macro ALU_ARB_STATS_EN undefined: counter logic absent, cnt0 and cnt1 tied to 16'h0000; all other behaviour identical.

Verification
REQ-033 req0 add a=5 b=7 alone, rsp_ready=1 -> req0_ready=1 cycle 0; cycle 1 rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
REQ-034 Both valid continuously after reset (req0 sub 9-9, req1 slt 3<4), rsp_ready=1 -> grants 0,1,0,1; results 0 (zero=1), 1 (zero=0) alternating.
REQ-035 req1 or 0xF0|0x0F with rsp_ready=0 for 3 cycles -> rsp_result=0xFF held stable, no further ready; rsp_ready=1 -> next request accepted same cycle.
REQ-036 req0 op 3'b110 a=1 b=1 -> rsp_err=1, rsp_result=0, rsp_zero=1, alu_control=000.
REQ-037 Reset asserted while rsp_valid=1 -> next cycle rsp_valid=0, prio=0, counters 0; both valid next -> requester 0 granted.
REQ-038 With ALU_ARB_STATS_EN, 70000 req1 accepts -> cnt1=16'hFFFF, cnt0=0; without macro both 0.
